// File: rtl/lfsr_prng_gen.sv
// lfsr_prng_gen
//   Parametrised Fibonacci LFSR pseudo-random generator with a valid/ready
//   output, lock-up recovery, full-period (wrap) detection and a beat counter.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   en         in   1      allow generation of new beats
//   seed_val   in   1      load seed this cycle
//   seed       in   WIDTH  seed value
//   out_ready  in   1      consumer accepts out_data
//   out_valid  out  1      out_data holds a fresh value
//   out_data   out  WIDTH  generated value
//   lockup     out  1      1-cycle pulse: lock-up state replaced by RST_SEED
//   wrap       out  1      1-cycle pulse: produced value equals start value
//   step_cnt   out  CNT_W  beats generated since last seed/reset
module lfsr_prng_gen #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   TAPS     = 8'hB8,
    parameter int                 USE_XNOR = 0,
    parameter int                 STEPS    = 1,
    parameter logic [WIDTH-1:0]   RST_SEED = 1,
    parameter int                 CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_val,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             lockup,
    output logic             wrap,
    output logic [CNT_W-1:0] step_cnt
);

    // The state an XOR LFSR can never leave is all-zeros; for XNOR it is all-ones.
    localparam logic [WIDTH-1:0] LOCK = (USE_XNOR != 0) ? '1 : '0;

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q,  wrap_d;

    logic [WIDTH-1:0] nxt;
    logic             advance;

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
        logic fb;
        fb = (^(s & TAPS)) ^ (USE_XNOR != 0);
        return {s[WIDTH-2:0], fb};
    endfunction

    // STEPS shifts chained combinationally so one beat covers the whole group.
    always_comb begin
        nxt = state_q;
        for (int i = 0; i < STEPS; i++) begin
            nxt = shift_once(nxt);
        end
    end

    // A held, unaccepted beat blocks generation regardless of en.
    assign advance = en && (!valid_q || out_ready);

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        data_d   = data_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;
        if (seed_val) begin
            // Seeding discards any pending beat and restarts the count.
            valid_d = 1'b0;
            cnt_d   = '0;
            if (seed == LOCK) begin
                state_d  = RST_SEED;
                start_d  = RST_SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = seed;
                start_d = seed;
            end
        end else if (advance) begin
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (state_q == LOCK) begin
                // Upset into the dead state: emit the recovery seed instead.
                state_d  = RST_SEED;
                data_d   = RST_SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = nxt;
                data_d  = nxt;
                wrap_d  = (nxt == start_q);
            end
        end else if (valid_q && out_ready) begin
            // Accepted with en low: the beat is consumed, state holds.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_SEED;
            start_q  <= RST_SEED;
            data_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign lockup    = lockup_q;
    assign wrap      = wrap_q;
    assign step_cnt  = cnt_q;

endmodule
